// File: rtl/tick_timer.sv
// tick_timer: programmable countdown timer clocked by divider ticks.
// Counts i_tick pulses (not system clocks) from a loaded interval down to
// expiry, then either reloads (auto-reload) or stops (one-shot). Each expiry
// raises a one-clk o_expired pulse and sets the sticky o_irq flag, which the
// CPU clears with i_irq_ack.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_tick         timebase enable, one clk wide per divider period
//   i_load         strobe: capture i_load_value into reload and count
//   i_load_value   interval in ticks
//   i_start        strobe: begin/resume counting
//   i_stop         strobe: pause counting, count held
//   i_auto_reload  level, sampled at the expiry edge
//   i_irq_ack      strobe: clear o_irq
//   o_count        remaining ticks
//   o_running      1 while in RUN
//   o_expired      one-clk pulse per expiry
//   o_irq          sticky interrupt pending
module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_auto_reload,
  input  logic             i_irq_ack,
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_expired,
  output logic             o_irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic             r_expired, w_expired_nxt;
  logic             r_irq, w_irq_nxt;
  logic             w_expire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_expired <= w_expired_nxt;
      r_irq     <= w_irq_nxt;
    end
  end

  // Strobe priority: load > stop > start > tick. A start in RUN and a stop
  // in IDLE do nothing, so they do not swallow a tick on that edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_expire     = 1'b0;
    if (i_load) begin
      w_reload_nxt = i_load_value;
      w_count_nxt  = i_load_value;
      // A zero interval can never expire, so park in IDLE to avoid wrap.
      if (i_load_value == '0) w_state_nxt = IDLE;
    end else if (i_stop && r_state == RUN) begin
      w_state_nxt = IDLE;
    end else if (i_start && r_state == IDLE) begin
      if (r_count != '0) w_state_nxt = RUN;
    end else if (i_tick && r_state == RUN) begin
      if (r_count > WIDTH'(1)) begin
        w_count_nxt = r_count - WIDTH'(1);
      end else begin
        w_expire = 1'b1;
        if (i_auto_reload && r_reload != '0) begin
          w_count_nxt = r_reload;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
    end
    w_expired_nxt = w_expire;
    // Set beats acknowledge when they land on the same edge.
    w_irq_nxt     = w_expire | (r_irq & ~i_irq_ack);
  end

  assign o_count   = r_count;
  assign o_running = (r_state == RUN);
  assign o_expired = r_expired;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic         auto_reload = 1'b0, irq_ack = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         running, expired, irq;

  int n_checks = 0;
  int n_pass   = 0;

  tick_timer #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_load(load),
    .i_load_value(load_value), .i_start(start), .i_stop(stop),
    .i_auto_reload(auto_reload), .i_irq_ack(irq_ack),
    .o_count(count), .o_running(running), .o_expired(expired), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: advance one edge, then settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v; cyc(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  // One tick edge; reports o_expired right after it, then 3 quiet clocks
  // (tick every 4 clk). Also reports whether expired lingered afterwards.
  task automatic tick_once(output logic exp_now, output logic exp_late);
    tick = 1'b1; cyc(); tick = 1'b0;
    exp_now  = expired;
    exp_late = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (expired) exp_late = 1'b1;
    end
  endtask

  task automatic test_reset();
    n_checks++; if ({count, running, expired, irq} !== '0) $display("FAIL reset_init got cnt=%0d run=%b exp=%b irq=%b want 0", count, running, expired, irq); else n_pass++;
    rst_n = 1'b1; cyc();
    do_load(16'd5); do_start();
    n_checks++; if (count !== 16'd5 || running !== 1'b1) $display("FAIL reset_pre got cnt=%0d run=%b want 5/1", count, running); else n_pass++;
    #2 rst_n = 1'b0; #1;
    n_checks++; if ({count, running, expired, irq} !== '0) $display("FAIL reset_async got cnt=%0d run=%b exp=%b irq=%b want 0", count, running, expired, irq); else n_pass++;
    cyc(); #2 rst_n = 1'b1; cyc();
    do_start();
    n_checks++; if (running !== 1'b0 || count !== 16'd0) $display("FAIL reset_start got run=%b cnt=%0d want 0/0", running, count); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic e, l, any;
    auto_reload = 1'b0;
    do_load(16'd3); do_start();
    n_checks++; if (count !== 16'd3 || running !== 1'b1) $display("FAIL os_start got cnt=%0d run=%b want 3/1", count, running); else n_pass++;
    tick_once(e, l);
    n_checks++; if (count !== 16'd2 || e !== 1'b0) $display("FAIL os_t1 got cnt=%0d exp=%b want 2/0", count, e); else n_pass++;
    tick_once(e, l);
    n_checks++; if (count !== 16'd1 || e !== 1'b0) $display("FAIL os_t2 got cnt=%0d exp=%b want 1/0", count, e); else n_pass++;
    tick_once(e, l);
    n_checks++; if (count !== 16'd0 || e !== 1'b1 || l !== 1'b0) $display("FAIL os_t3 got cnt=%0d exp=%b late=%b want 0/1/0", count, e, l); else n_pass++;
    n_checks++; if (irq !== 1'b1 || running !== 1'b0) $display("FAIL os_flags got irq=%b run=%b want 1/0", irq, running); else n_pass++;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin tick_once(e, l); any |= e | l; end
    n_checks++; if (count !== 16'd0 || any !== 1'b0) $display("FAIL os_after got cnt=%0d exp=%b want 0/0", count, any); else n_pass++;
    do_ack();
    n_checks++; if (irq !== 1'b0) $display("FAIL os_ack got irq=%b want 0", irq); else n_pass++;
  endtask

  task automatic test_auto_reload();
    logic e, l;
    logic [W-1:0] exp_cnt;
    int bad;
    bad = 0;
    auto_reload = 1'b1;
    do_load(16'd2); do_start();
    for (int k = 1; k <= 6; k++) begin
      tick_once(e, l);
      exp_cnt = (k % 2 == 0) ? 16'd2 : 16'd1;
      n_checks++;
      if (count !== exp_cnt || e !== (k % 2 == 0) || l !== 1'b0 || running !== 1'b1) begin
        $display("FAIL ar_tick%0d got cnt=%0d exp=%b late=%b run=%b want %0d/%b/0/1", k, count, e, l, running, exp_cnt, (k % 2 == 0));
        bad++;
      end else n_pass++;
    end
    auto_reload = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    do_ack();
  endtask

  task automatic test_stop_resume();
    logic e, l, any;
    auto_reload = 1'b0;
    do_load(16'd5); do_start();
    tick_once(e, l); tick_once(e, l);
    n_checks++; if (count !== 16'd3) $display("FAIL sr_run got cnt=%0d want 3", count); else n_pass++;
    stop = 1'b1; cyc(); stop = 1'b0;
    n_checks++; if (running !== 1'b0 || count !== 16'd3) $display("FAIL sr_stop got run=%b cnt=%0d want 0/3", running, count); else n_pass++;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin tick_once(e, l); any |= e | l; end
    n_checks++; if (count !== 16'd3 || any !== 1'b0) $display("FAIL sr_held got cnt=%0d exp=%b want 3/0", count, any); else n_pass++;
    // Tick coinciding with the start edge must not be counted.
    start = 1'b1; tick = 1'b1; cyc(); start = 1'b0; tick = 1'b0;
    n_checks++; if (running !== 1'b1 || count !== 16'd3) $display("FAIL sr_resume got run=%b cnt=%0d want 1/3", running, count); else n_pass++;
    tick_once(e, l); tick_once(e, l);
    n_checks++; if (count !== 16'd1 || e !== 1'b0) $display("FAIL sr_t2 got cnt=%0d exp=%b want 1/0", count, e); else n_pass++;
    tick_once(e, l);
    n_checks++; if (count !== 16'd0 || e !== 1'b1 || running !== 1'b0 || irq !== 1'b1) $display("FAIL sr_exp got cnt=%0d exp=%b run=%b irq=%b want 0/1/0/1", count, e, running, irq); else n_pass++;
  endtask

  task automatic test_collisions();
    logic e, l;
    // irq is still pending from the previous expiry here.
    do_load(16'd2); do_start();
    tick_once(e, l);
    n_checks++; if (count !== 16'd1) $display("FAIL col_pre got cnt=%0d want 1", count); else n_pass++;
    tick = 1'b1; stop = 1'b1; cyc(); tick = 1'b0; stop = 1'b0;
    n_checks++; if (count !== 16'd1 || running !== 1'b0 || expired !== 1'b0) $display("FAIL col_stop got cnt=%0d run=%b exp=%b want 1/0/0", count, running, expired); else n_pass++;
    do_start();
    tick = 1'b1; load = 1'b1; load_value = 16'd7; cyc(); tick = 1'b0; load = 1'b0;
    n_checks++; if (count !== 16'd7 || running !== 1'b1 || expired !== 1'b0) $display("FAIL col_load got cnt=%0d run=%b exp=%b want 7/1/0", count, running, expired); else n_pass++;
    do_load(16'd1);
    tick = 1'b1; irq_ack = 1'b1; cyc(); tick = 1'b0; irq_ack = 1'b0;
    n_checks++; if (expired !== 1'b1 || irq !== 1'b1 || running !== 1'b0) $display("FAIL col_ack got exp=%b irq=%b run=%b want 1/1/0", expired, irq, running); else n_pass++;
    cyc();
    n_checks++; if (expired !== 1'b0 || irq !== 1'b1) $display("FAIL col_pulse got exp=%b irq=%b want 0/1", expired, irq); else n_pass++;
    do_ack();
    n_checks++; if (irq !== 1'b0) $display("FAIL col_ack2 got irq=%b want 0", irq); else n_pass++;
  endtask

  task automatic test_zero_load();
    logic e, l, any;
    do_load(16'd3); do_start();
    n_checks++; if (running !== 1'b1) $display("FAIL zl_run got run=%b want 1", running); else n_pass++;
    do_load(16'd0);
    n_checks++; if (running !== 1'b0 || count !== 16'd0) $display("FAIL zl_load got run=%b cnt=%0d want 0/0", running, count); else n_pass++;
    do_start();
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin tick_once(e, l); any |= e | l | running; end
    n_checks++; if (any !== 1'b0 || count !== 16'd0 || irq !== 1'b0) $display("FAIL zl_start got act=%b cnt=%0d irq=%b want 0/0/0", any, count, irq); else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_stop_resume();
    test_collisions();
    test_zero_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule
